// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic phase-step controller.
package pll_ctrl_pkg;
  localparam int CNT_SEL_W_DFLT = 4;
  localparam int PHASE_ACC_W    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP    = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    SETTLE  = 3'd4,
    RESP    = 3'd5
  } state_e;
endpackage

// File: rtl/pll_sync_2ff.sv
// 1-bit two-flop synchronizer for PLL status inputs; clears to 0 on reset.
module pll_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Sequences altpll dynamic phase shifting: N single-step pulses, then lock confirm.
// Optional net-step accumulator on phase_acc: define PLL_PHASE_STEP_CTRL_ACC_EN.
module pll_phase_step_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int CNT_SEL_W   = CNT_SEL_W_DFLT,
  parameter int STEP_W      = 8,
  parameter int PULSE_CYC   = 2,
  parameter int DONE_TMO    = 255,
  parameter int LOCK_SETTLE = 16
) (
  input  logic                   inclk0,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CNT_SEL_W-1:0]   req_cnt_sel,
  input  logic                   req_updown,
  input  logic [STEP_W-1:0]      req_steps,
  output logic                   phasestep,
  output logic [CNT_SEL_W-1:0]   phasecounterselect,
  output logic                   phaseupdown,
  input  logic                   phasedone,
  input  logic                   locked,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [STEP_W-1:0]      rsp_steps,
  output logic [PHASE_ACC_W-1:0] phase_acc
);
  localparam int PW      = $clog2(PULSE_CYC + 1);
  localparam int TMO_MAX = DONE_TMO * 4;
  localparam int TW      = $clog2(TMO_MAX + 1);
  localparam int LW      = $clog2(LOCK_SETTLE + 1);

  state_e                state_q;
  logic                  ready_q, step_q, dir_q, err_q, rsp_valid_q, rsp_err_q;
  logic [CNT_SEL_W-1:0]  sel_q;
  logic [STEP_W-1:0]     steps_q, done_cnt_q, done_cnt_d, rsp_steps_q;
  logic [PW-1:0]         pulse_q;
  logic [TW-1:0]         tmo_q;
  logic [LW-1:0]         lock_q;
  logic                  done_s, locked_s;

  pll_sync_2ff u_sync_done (.clk(inclk0), .rst_n(rst_n), .d(phasedone), .q(done_s));
  pll_sync_2ff u_sync_lock (.clk(inclk0), .rst_n(rst_n), .d(locked),    .q(locked_s));

  assign done_cnt_d = done_cnt_q + STEP_W'(1);

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      sel_q       <= '0;
      steps_q     <= '0;
      done_cnt_q  <= '0;
      err_q       <= 1'b0;
      pulse_q     <= '0;
      tmo_q       <= '0;
      lock_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_steps_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // One dead cycle after a response before the next accept.
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (req_valid) begin
            ready_q    <= 1'b0;
            sel_q      <= req_cnt_sel;
            dir_q      <= req_updown;
            steps_q    <= req_steps;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
            pulse_q    <= '0;
            if (req_steps != '0) begin
              state_q <= STEP;
              step_q  <= 1'b1;
            end else begin
              state_q <= RESP;
            end
          end
        end
        STEP: begin
          if (pulse_q == PW'(PULSE_CYC - 1)) begin
            step_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= WAIT_LO;
          end else begin
            pulse_q <= pulse_q + PW'(1);
          end
        end
        WAIT_LO: begin
          if (!done_s) begin
            tmo_q   <= '0;
            state_q <= WAIT_HI;
          end else if (tmo_q >= TW'(DONE_TMO - 1)) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WAIT_HI: begin
          if (done_s) begin
            done_cnt_q <= done_cnt_d;
            pulse_q    <= '0;
            tmo_q      <= '0;
            if (done_cnt_d == steps_q) begin
              lock_q  <= '0;
              state_q <= SETTLE;
            end else begin
              step_q  <= 1'b1;
              state_q <= STEP;
            end
          end else if (tmo_q >= TW'(DONE_TMO - 1)) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        SETTLE: begin
          // Lock run-length restarts on any dropout; overall budget is 4x the step timeout.
          lock_q <= locked_s ? lock_q + LW'(1) : '0;
          if (tmo_q < TW'(TMO_MAX)) tmo_q <= tmo_q + TW'(1);
          if (locked_s && lock_q >= LW'(LOCK_SETTLE - 1)) begin
            state_q <= RESP;
          end else if (tmo_q >= TW'(TMO_MAX - 1)) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_steps_q <= done_cnt_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready          = ready_q;
  assign phasestep          = step_q;
  assign phasecounterselect = sel_q;
  assign phaseupdown        = dir_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_steps          = rsp_steps_q;

`ifdef PLL_PHASE_STEP_CTRL_ACC_EN
  localparam logic signed [PHASE_ACC_W-1:0] ACC_MAX = {1'b0, {(PHASE_ACC_W-1){1'b1}}};
  localparam logic signed [PHASE_ACC_W-1:0] ACC_MIN = {1'b1, {(PHASE_ACC_W-1){1'b0}}};
  localparam logic signed [PHASE_ACC_W-1:0] ACC_ONE = 1;

  logic signed [PHASE_ACC_W-1:0] acc_q, acc_d;
  logic                          step_done;

  assign step_done = (state_q == WAIT_HI) && done_s;

  always_comb begin
    acc_d = acc_q;
    if (step_done) begin
      if (dir_q && acc_q != ACC_MAX)       acc_d = acc_q + ACC_ONE;
      else if (!dir_q && acc_q != ACC_MIN) acc_d = acc_q - ACC_ONE;
    end
  end

  always_ff @(posedge inclk0) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign phase_acc = acc_q;
`else
  assign phase_acc = '0;
`endif
endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Randomized self-checking bench for pll_phase_step_ctrl with a behavioural PLL and outcome model.
module tb_pll_phase_step_ctrl;
  localparam int CSW = 4, SW = 8, PULSE = 2, TMO = 255, SETTLE_N = 16;
`ifdef PLL_PHASE_STEP_CTRL_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic           inclk0 = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_updown = 1'b0;
  logic           phasedone = 1'b1, locked = 1'b1;
  logic [CSW-1:0] req_cnt_sel = '0;
  logic [SW-1:0]  req_steps = '0;
  logic           req_ready, phasestep, phaseupdown, rsp_valid, rsp_err;
  logic [CSW-1:0] phasecounterselect;
  logic [SW-1:0]  rsp_steps;
  logic [15:0]    phase_acc;

  pll_phase_step_ctrl dut (
    .inclk0(inclk0), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cnt_sel(req_cnt_sel), .req_updown(req_updown), .req_steps(req_steps),
    .phasestep(phasestep), .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasedone(phasedone), .locked(locked), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_steps(rsp_steps), .phase_acc(phase_acc)
  );

  always #5 inclk0 = ~inclk0;

  int cyc = 0;
  always @(posedge inclk0) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit inflight = 0, prev_rsp = 0, rsp_seen = 0;
  int pulses = 0, ps_w = 0, fall_cyc = 0, rsp_cyc = 0;
  int exp_sel = 0, exp_dir = 0, exp_err = 0, exp_steps = 0, exp_pulses = 0, exp_acc = 0;
  int last_err = 0, last_steps = 0;
  int pll_limit = 255, pll_seen = 0, answered = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int acc_after(input int a, input int dir, input int n);
    int r;
    if (!ACC_ON) return 0;
    r = dir ? a + n : a - n;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // PLL model: each answered phasestep yields a phasedone low pulse ~4 cycles later.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge inclk0);
      if (phasestep && !prev) begin
        pll_seen++;
        if (pll_seen <= pll_limit) begin
          repeat (3) @(negedge inclk0);
          #1 phasedone = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge inclk0);
          #1 phasedone = 1'b1;
          answered++;
        end
      end
      prev = phasestep;
    end
  end

  // Per-cycle comparison against the transaction-level expectations.
  always @(negedge inclk0) begin
    if (!rst_n) begin
      ps_w = 0; prev_rsp = 0; inflight = 0;
      last_err = 0; last_steps = 0; exp_acc = 0;
    end else begin
      if (prev_rsp) chk("ready_after_rsp", int'(req_ready), 1);
      prev_rsp = 0;
      if (phasestep) begin
        if (ps_w == 0) pulses++;
        ps_w++;
      end else if (ps_w != 0) begin
        chk("pulse_width", ps_w, PULSE);
        ps_w = 0;
        fall_cyc = cyc;
      end
      if (inflight) begin
        chk("busy_ready", int'(req_ready), 0);
        chk("busy_sel", int'(phasecounterselect), exp_sel);
        chk("busy_dir", int'(phaseupdown), exp_dir);
        if (rsp_valid) begin
          chk("rsp_err", int'(rsp_err), exp_err);
          chk("rsp_steps", int'(rsp_steps), exp_steps);
          chk("rsp_pulses", pulses, exp_pulses);
          chk("rsp_acc", int'($signed(phase_acc)), exp_acc);
          last_err = rsp_err; last_steps = rsp_steps;
          rsp_cyc = cyc; rsp_seen = 1; inflight = 0; prev_rsp = 1;
        end
      end else begin
        chk("idle_rsp_valid", int'(rsp_valid), 0);
        chk("idle_step", int'(phasestep), 0);
        chk("idle_acc", int'($signed(phase_acc)), exp_acc);
        chk("hold_err", int'(rsp_err), last_err);
        chk("hold_steps", int'(rsp_steps), last_steps);
      end
    end
  end

  // Issue one request and wait for its response; limit = steps the PLL model will answer.
  task automatic do_req(input int sel, input int dir, input int steps, input int limit,
                        input bit lockfail, input bit glitch);
    int n, acc_cyc, up_cyc, nxt_acc;
    exp_sel    = sel;
    exp_dir    = dir;
    exp_pulses = (limit >= steps) ? steps : limit + 1;
    exp_steps  = (limit >= steps) ? steps : limit;
    exp_err    = ((limit < steps) || (lockfail && steps != 0)) ? 1 : 0;
    nxt_acc    = acc_after(exp_acc, dir, exp_steps);
    pulses = 0; pll_seen = 0; pll_limit = limit; answered = 0; rsp_seen = 0; up_cyc = 0;
    if (lockfail) locked = 1'b0;
    @(posedge inclk0); #1;
    req_valid = 1'b1; req_cnt_sel = CSW'(sel); req_updown = dir[0]; req_steps = SW'(steps);
    n = 0;
    do begin @(negedge inclk0); n++; end while (!req_ready && n < 3000);
    if (!req_ready) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge inclk0); #1;
    req_valid = 1'b0; inflight = 1; exp_acc = nxt_acc;
    req_cnt_sel = CSW'($urandom); req_updown = ~req_updown; req_steps = SW'($urandom);
    if (glitch) begin
      n = 0;
      while (answered < steps && n < 5000) begin @(negedge inclk0); n++; end
      repeat (4) @(negedge inclk0);
      #1 locked = 1'b0;
      repeat (3) @(negedge inclk0);
      #1 locked = 1'b1;
      up_cyc = cyc;
    end
    n = 0;
    while (!rsp_seen && n < 5000) begin @(negedge inclk0); n++; end
    if (!rsp_seen) begin
      chk("rsp_timeout", 0, 1);
      inflight = 0;
    end else begin
      if (steps == 0) chk("zero_latency", rsp_cyc - acc_cyc, 2);
      if (limit < steps)
        chk("tmo_window", int'((rsp_cyc - fall_cyc >= TMO) && (rsp_cyc - fall_cyc <= TMO + 3)), 1);
      if (glitch) chk("glitch_settle", int'(rsp_cyc - up_cyc >= SETTLE_N), 1);
    end
    locked = 1'b1;
    repeat (2) @(negedge inclk0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge inclk0);
    @(negedge inclk0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_step", int'(phasestep), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_acc", int'($signed(phase_acc)), 0);
    chk("rst_sel", int'(phasecounterselect), 0);
    chk("rst_updown", int'(phaseupdown), 0);
    chk("rst_rsp_steps", int'(rsp_steps), 0);
    @(posedge inclk0); #1 rst_n = 1'b1;
    repeat (2) @(negedge inclk0);

    do_req(2, 1, 3, 255, 0, 0);
    chk("nom_steps", last_steps, 3);
    chk("nom_err", last_err, 0);
    chk("nom_acc", int'($signed(phase_acc)), ACC_ON ? 3 : 0);

    do_req(5, 0, 0, 255, 0, 0);
    chk("zero_steps", last_steps, 0);
    chk("zero_err", last_err, 0);

    do_req(7, 1, 5, 2, 0, 0);
    chk("tmo_steps", last_steps, 2);
    chk("tmo_err", last_err, 1);
    chk("tmo_acc", int'($signed(phase_acc)), ACC_ON ? 5 : 0);

    do_req(1, 0, 2, 255, 0, 1);
    chk("glitch_err", last_err, 0);
    chk("glitch_acc", int'($signed(phase_acc)), ACC_ON ? 3 : 0);

    do_req(3, 1, 1, 255, 1, 0);
    chk("lockfail_err", last_err, 1);
    chk("lockfail_steps", last_steps, 1);

    // Reset during the second phasestep pulse.
    pulses = 0; pll_seen = 0; pll_limit = 255; answered = 0; rsp_seen = 0;
    exp_sel = 4; exp_dir = 1;
    @(posedge inclk0); #1;
    req_valid = 1'b1; req_cnt_sel = 4'd4; req_updown = 1'b1; req_steps = 8'd4;
    n = 0;
    do begin @(negedge inclk0); n++; end while (!req_ready && n < 3000);
    @(posedge inclk0); #1 req_valid = 1'b0; inflight = 1;
    n = 0;
    while (pulses < 2 && n < 3000) begin @(negedge inclk0); n++; end
    chk("mid_second_pulse", int'(phasestep), 1);
    #1 rst_n = 1'b0;
    @(negedge inclk0);
    chk("mid_rst_step_drop", int'(phasestep), 0);
    chk("mid_rst_no_rsp", int'(rsp_valid), 0);
    @(posedge inclk0); #1 rst_n = 1'b1;
    @(negedge inclk0);
    chk("mid_rst_ready", int'(req_ready), 1);
    repeat (20) @(negedge inclk0);
    do_req(6, 0, 2, 255, 0, 0);
    chk("post_rst_steps", last_steps, 2);
    chk("post_rst_acc", int'($signed(phase_acc)), ACC_ON ? -2 : 0);

    for (int i = 0; i < 25; i++) begin
      int s, l;
      s = $urandom_range(0, 6);
      l = 255;
      if (s != 0 && $urandom_range(0, 5) == 0) l = $urandom_range(0, s - 1);
      do_req($urandom_range(0, 15), $urandom_range(0, 1), s, l, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
